// File: rtl/soc_system_sysid_pkg.sv
// Shared constants for the system-identification register bank.
// Holds the word-address map, CAPS field offsets, the legal READ_LATENCY
// range and a helper that assembles the CAPS word.
package soc_system_sysid_pkg;

  // Word-address map
  localparam int unsigned AddrId        = 0;
  localparam int unsigned AddrTimestamp = 1;
  localparam int unsigned AddrScratch   = 2;
  localparam int unsigned AddrCaps      = 3;
  localparam int unsigned AddrUptimeLo  = 4;
  localparam int unsigned AddrUptimeHi  = 5;
  localparam int unsigned AddrInfoBase  = 6;

  // CAPS field offsets
  localparam int unsigned CapsUptimeBit = 0;
  localparam int unsigned CapsLatLsb    = 2;
  localparam int unsigned CapsNinfoLsb  = 8;
  localparam int unsigned CapsAddrwLsb  = 16;

  // Legal READ_LATENCY range
  localparam int unsigned ReadLatMin = 1;
  localparam int unsigned ReadLatMax = 3;

  function automatic logic [31:0] caps_word(input bit          uptime,
                                            input int unsigned lat,
                                            input int unsigned ninfo,
                                            input int unsigned addrw);
    logic [31:0] w;
    w = '0;
    w[CapsUptimeBit]       = uptime;
    w[CapsLatLsb +: 2]     = lat[1:0];
    w[CapsNinfoLsb +: 8]   = ninfo[7:0];
    w[CapsAddrwLsb +: 8]   = addrw[7:0];
    return w;
  endfunction

endpackage

// File: rtl/soc_system_sysid_rdpipe.sv
// Fixed-latency read-response pipeline.
// Shifts a valid strobe and its data through LATENCY register stages. Data is
// zeroed whenever the accompanying valid is low, so the output data is 0 on
// every cycle without a response.
// Ports:
//   clock     - sole clock
//   reset_n   - synchronous active-low reset, flushes all stages
//   in_valid  - read accepted this cycle
//   in_data   - decoded read data for the accepted read
//   out_valid - response strobe, LATENCY cycles after in_valid
//   out_data  - response data, 0 when out_valid is low
module soc_system_sysid_rdpipe #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        out_valid,
  output logic [31:0] out_data
);

  logic [LATENCY-1:0] valid_q;
  logic [31:0]        data_q [LATENCY];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_valid ? in_data : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/soc_system_sysid_regs.sv
// System-identification register bank, Avalon-MM slave without waitrequest.
// Returns ID, build timestamp, CAPS and build-info words, provides a byte-
// enabled scratch register and, when the macro SYSID_UPTIME_EN is defined, a
// free-running 64-bit uptime counter read atomically as LO then HI (shadow).
// Ports:
//   clock, reset_n          - clock and synchronous active-low reset
//   address                 - word address
//   read, write             - requests; write wins when both are asserted
//   writedata, byteenable   - write data and byte lanes
//   readdata, readdatavalid - response, READ_LATENCY cycles after accept
module soc_system_sysid_regs
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE     = 32'h0000_00A5,
  parameter logic [31:0] TIMESTAMP    = 32'h5DA0_0000,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned NUM_INFO     = 2,
  parameter logic [((NUM_INFO > 0) ? NUM_INFO : 1)*32-1:0] INFO_WORDS = '0,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  if (READ_LATENCY < ReadLatMin || READ_LATENCY > ReadLatMax) begin : g_lat_check
    $error("READ_LATENCY out of range");
  end

`ifdef SYSID_UPTIME_EN
  localparam bit UptimeEn = 1'b1;
`else
  localparam bit UptimeEn = 1'b0;
`endif

  localparam logic [31:0] Caps = caps_word(UptimeEn, READ_LATENCY, NUM_INFO, ADDR_W);

  // A simultaneous write drops the read.
  logic rd_accept;
  assign rd_accept = read & ~write;

  // Scratch register
  logic [31:0] scratch_q, scratch_d;

  always_comb begin
    scratch_d = scratch_q;
    if (write && address == ADDR_W'(AddrScratch)) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) scratch_d[8*b +: 8] = writedata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) scratch_q <= '0;
    else          scratch_q <= scratch_d;
  end

  // Uptime counter and high-word shadow
  logic [31:0] uptime_lo, uptime_hi;

`ifdef SYSID_UPTIME_EN
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;

  always_comb begin
    cnt_d    = cnt_q + 64'd1;
    shadow_d = shadow_q;
    if (write && address == ADDR_W'(AddrUptimeLo) && byteenable != 4'h0) cnt_d = '0;
    // LO read captures HI of the same sample so the pair reads atomically.
    if (rd_accept && address == ADDR_W'(AddrUptimeLo)) shadow_d = cnt_q[63:32];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign uptime_lo = cnt_q[31:0];
  assign uptime_hi = shadow_q;
`else
  assign uptime_lo = '0;
  assign uptime_hi = '0;
`endif

  // Combinational read decode
  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    case (address)
      ADDR_W'(AddrId):        rd_data = ID_VALUE;
      ADDR_W'(AddrTimestamp): rd_data = TIMESTAMP;
      ADDR_W'(AddrScratch):   rd_data = scratch_q;
      ADDR_W'(AddrCaps):      rd_data = Caps;
      ADDR_W'(AddrUptimeLo):  rd_data = uptime_lo;
      ADDR_W'(AddrUptimeHi):  rd_data = uptime_hi;
      default: begin
        for (int i = 0; i < NUM_INFO; i++) begin
          if (address == ADDR_W'(AddrInfoBase + i)) rd_data = INFO_WORDS[32*i +: 32];
        end
      end
    endcase
  end

  soc_system_sysid_rdpipe #(
    .LATENCY (READ_LATENCY)
  ) u_rdpipe (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (rd_accept),
    .in_data   (rd_data),
    .out_valid (readdatavalid),
    .out_data  (readdata)
  );

endmodule
